// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
//   - SEG bus bit order: [7] = DP, [6:0] = g..a, all active-low.
//   - The 16 hex glyph patterns and the blank pattern, in active-low form.
//     The hex-to-segment decoder uses the same constants.
//   - Decoder result struct and the scan FSM state type.
package seg7_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h58;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h27;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Indexed by hex value: SEG_PATTERNS[v] is the glyph for v.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] val;
    } seg_decode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: display bus plus recovered-frame outputs.
//   master: drives seg/an (the display source), observes the frame outputs.
//   slave : the reader; samples seg/an, drives value/dp/blank/valid/err/stale.
interface seg7_scan_reader_if #(
    parameter int N_DIGITS = 4
);
    logic [7:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  valid;
    logic                  err;
    logic                  stale;

    modport master (
        output seg, an,
        input  value, dp, blank, valid, err, stale
    );

    modport slave (
        input  seg, an,
        output value, dp, blank, valid, err, stale
    );
endinterface

// File: rtl/seg7_pattern_to_hex.sv
// seg7_pattern_to_hex: combinational inverse of the hex-to-segment decoder.
//   seg_i : segment pattern g..a, active-low
//   dec_o : {err, blank, val}; blank and error patterns both yield val = 0
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0]  seg_i,
    output seg_decode_t dec_o
);

    always_comb begin
        dec_o     = '0;
        dec_o.err = 1'b1;
        if (seg_i == SEG_BLANK) begin
            dec_o.err   = 1'b0;
            dec_o.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg_i == SEG_PATTERNS[i]) begin
                    dec_o.err = 1'b0;
                    dec_o.val = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers hex digits from a scanned, active-low 7-segment bus.
//   clk_i : system clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : slave modport; seg/an in, value/dp/blank/valid/err/stale out
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | AN not one-hot-low; waiting for a digit to be selected
// ST_SETTLE | one digit selected, counting cycles of unchanged {SEG,AN}
// ST_HOLD   | digit sampled; waiting for AN to move on
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    seg7_scan_reader_if.slave bus
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [7:0]               seg_q;
    logic [N_DIGITS-1:0]      an_q;

    scan_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [7:0]               ref_seg_q, ref_seg_d;
    logic [N_DIGITS-1:0]      ref_an_q, ref_an_d;

    logic [N_DIGITS-1:0][3:0] slot_val_q, slot_val_d;
    logic [N_DIGITS-1:0]      slot_dp_q, slot_dp_d;
    logic [N_DIGITS-1:0]      slot_blank_q, slot_blank_d;
    logic [N_DIGITS-1:0]      slot_err_q, slot_err_d;
    logic [N_DIGITS-1:0]      mask_q, mask_d;

    logic [4*N_DIGITS-1:0]    value_q, value_d;
    logic [N_DIGITS-1:0]      dp_q, dp_d;
    logic [N_DIGITS-1:0]      blank_q, blank_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;

    logic                     an_onehot;
    logic [IDX_W-1:0]         an_idx;
    logic                     start;
    logic                     sample;
    logic                     commit;
    seg_decode_t              pat;

    seg7_pattern_to_hex u_pat (
        .seg_i (seg_q[6:0]),
        .dec_o (pat)
    );

    assign an_onehot = $onehot(~an_q);
    assign commit    = &mask_q;

    always_comb begin
        an_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) an_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ref_seg_d    = ref_seg_q;
        ref_an_d     = ref_an_q;
        slot_val_d   = slot_val_q;
        slot_dp_d    = slot_dp_q;
        slot_blank_d = slot_blank_q;
        slot_err_d   = slot_err_q;
        mask_d       = mask_q;
        value_d      = value_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        valid_d      = 1'b0;
        err_d        = err_q;
        tmo_d        = tmo_q;
        start        = 1'b0;
        sample       = 1'b0;

        // A new one-hot selection (from any state) opens a dwell directly,
        // so a scan going straight from one digit to the next loses no cycle.
        case (state_q)
            ST_IDLE: begin
                if (an_onehot) start = 1'b1;
            end
            ST_SETTLE: begin
                if ({seg_q, an_q} != {ref_seg_q, ref_an_q}) begin
                    if (an_onehot) start = 1'b1;
                    else           state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    sample  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (an_q != ref_an_q) begin
                    if (an_onehot) start = 1'b1;
                    else           state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The first stable cycle is the one that opens the dwell; the
        // down-counter holds the number of further stable cycles needed.
        if (start) begin
            ref_seg_d = seg_q;
            ref_an_d  = an_q;
            if (SETTLE_CYCLES == 1) begin
                sample  = 1'b1;
                state_d = ST_HOLD;
            end else begin
                state_d = ST_SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end
        end

        // Commit runs before the sample write so a same-cycle sample
        // lands in the freshly cleared mask of the next frame.
        if (commit) begin
            value_d    = slot_val_q;
            dp_d       = slot_dp_q;
            blank_d    = slot_blank_q;
            err_d      = |slot_err_q;
            valid_d    = 1'b1;
            mask_d     = '0;
            slot_err_d = '0;
        end

        if (sample) begin
            slot_val_d[an_idx]   = pat.val;
            slot_dp_d[an_idx]    = ~seg_q[SEG_DP_BIT];
            slot_blank_d[an_idx] = pat.blank;
            slot_err_d[an_idx]   = pat.err;
            mask_d[an_idx]       = 1'b1;
        end

        if (commit)             tmo_d = TMO_W'(TIMEOUT_CYCLES);
        else if (tmo_q != '0)   tmo_d = tmo_q - TMO_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_q        <= '1;
            an_q         <= '1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ref_seg_q    <= '1;
            ref_an_q     <= '1;
            slot_val_q   <= '0;
            slot_dp_q    <= '0;
            slot_blank_q <= '1;
            slot_err_q   <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            dp_q         <= '0;
            blank_q      <= '1;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= TMO_W'(TIMEOUT_CYCLES);
        end else begin
            seg_q        <= bus.seg;
            an_q         <= bus.an;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_seg_q    <= ref_seg_d;
            ref_an_q     <= ref_an_d;
            slot_val_q   <= slot_val_d;
            slot_dp_q    <= slot_dp_d;
            slot_blank_q <= slot_blank_d;
            slot_err_q   <= slot_err_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.value = value_q;
    assign bus.dp    = dp_q;
    assign bus.blank = blank_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    // Timeout counts down from TIMEOUT_CYCLES; zero means no frame for that long.
    assign bus.stale = (tmo_q == '0);

endmodule
